button_conditioner: RTL and testbench

Front-end stage for the whack-a-mole game core: takes the raw, asynchronous, active-low push-button pins and produces clean, synchronised, debounced levels plus single-cycle press/release strobes in the `clk` domain. The game logic consumes `press_pulse` in place of its own edge detection on `in1`..`in5`. All channels are identical and independent.

---
 rtl/game_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 108 ++++++++++
 rtl/button_conditioner.sv | 55 +++++
 tb/tb_button_conditioner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game core front end.
//
// Contents:
//   BTN_IDLE       - electrical level of an idle (released) button pin; pins are active-low
//   DEBOUNCE_10MS  - debounce window in clk cycles (10 ms at 100 MHz)
//   N_GAME_BTN     - number of game buttons
//   btn_state_e    - debounced stable state of one button
//   level_to_state - maps a synchronised pin level onto btn_state_e
package game_pkg;

  localparam logic        BTN_IDLE      = 1'b1;
  localparam int unsigned DEBOUNCE_10MS = 1000000;
  localparam int unsigned N_GAME_BTN    = 5;

  typedef enum logic {
    StReleased = 1'b0,
    StPressed  = 1'b1
  } btn_state_e;

  function automatic btn_state_e level_to_state(input logic level);
    return (level == BTN_IDLE) ? StReleased : StPressed;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: two-flop synchroniser, stability counter, accepted
// state and registered level/strobe outputs.
//
// Ports:
//   clk              - system clock
//   reset            - asynchronous reset, active-low
//   btn_raw          - raw pin, active-low, asynchronous to clk
//   pressed          - debounced level, 1 = held
//   press_pulse      - one-cycle strobe when a press is accepted
//   release_pulse    - one-cycle strobe when a release is accepted
//   press_pulse_next - next-state of press_pulse, so the parent can register an
//                      aggregate that lines up with the strobe
module debounce_channel
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_pulse_next
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_s1;
  logic            r_s2;
  btn_state_e      r_st;
  btn_state_e      w_st_next;
  btn_state_e      w_s2_state;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            w_accept;
  logic            w_press_next;
  logic            w_release_next;
  logic            r_pressed;
  logic            r_press_pulse;
  logic            r_release_pulse;

  // Synchroniser resets to the idle level so a released button is quiet after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= BTN_IDLE;
      r_s2 <= BTN_IDLE;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st  <= StReleased;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Next state: count consecutive cycles where the synchronised level disagrees
  // with the accepted state; any agreement restarts the window.
  always_comb begin
    w_s2_state = level_to_state(r_s2);
    w_accept   = 1'b0;
    w_st_next  = r_st;
    w_cnt_next = r_cnt;
    if (w_s2_state == r_st) begin
      w_cnt_next = '0;
    end else if (r_cnt == CntLast) begin
      w_accept   = 1'b1;
      w_st_next  = w_s2_state;
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + CntW'(1);
    end
  end

  // Output decode: strobes are qualified by the direction of the accepted flip.
  always_comb begin
    w_press_next   = w_accept && (w_st_next == StPressed);
    w_release_next = w_accept && (w_st_next == StReleased);
  end

  // Output registers change on the same edge that flips the accepted state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      r_pressed       <= (w_st_next == StPressed);
      r_press_pulse   <= w_press_next;
      r_release_pulse <= w_release_next;
    end
  end

  assign pressed          = r_pressed;
  assign press_pulse      = r_press_pulse;
  assign release_pulse    = r_release_pulse;
  assign press_pulse_next = w_press_next;

endmodule

// File: rtl/button_conditioner.sv
// Button front end for the game core: N_BTN independent debounce channels
// turning raw active-low pins into clean levels and press/release strobes.
//
// Ports:
//   clk           - system clock, all state in this domain
//   reset         - asynchronous reset, active-low
//   btn_raw       - raw button pins, active-low, asynchronous
//   pressed       - debounced levels, 1 = held
//   press_pulse   - one-cycle strobes on accepted presses
//   release_pulse - one-cycle strobes on accepted releases
//   any_press     - OR of press_pulse, registered in the same cycle as the strobes
module button_conditioner
  import game_pkg::*;
#(
  parameter int unsigned N_BTN           = N_GAME_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_press
);

  logic [N_BTN-1:0] w_press_next;
  logic             r_any_press;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk             (clk),
      .reset           (reset),
      .btn_raw         (btn_raw[g]),
      .pressed         (pressed[g]),
      .press_pulse     (press_pulse[g]),
      .release_pulse   (release_pulse[g]),
      .press_pulse_next(w_press_next[g])
    );
  end

  // Built from the channels' next-state strobes so it aligns with press_pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_next;
    end
  end

  assign any_press = r_any_press;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int unsigned N = 5;
  localparam int unsigned D = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] pressed, press_pulse, release_pulse;
  logic         any_press;

  int n_chk = 0;
  int n_err = 0;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_press    (any_press)
  );

  always #5 clk = ~clk;

  // Behavioural model: the pin is seen two edges late; a new level is accepted
  // once the last D samples all disagree with the currently held level.
  logic [N-1:0] m_d1, m_d2, m_held, m_pp, m_rp;
  logic         m_any;
  bit           m_hist[N][$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_d1 = '1; m_d2 = '1; m_held = '0; m_pp = '0; m_rp = '0; m_any = 1'b0;
      for (int c = 0; c < N; c++) m_hist[c].delete();
    end else begin
      for (int c = 0; c < N; c++) begin
        bit samp, all_diff;
        samp = ~m_d2[c];
        m_hist[c].push_back(samp);
        if (m_hist[c].size() > D) void'(m_hist[c].pop_front());
        all_diff = (m_hist[c].size() == D);
        foreach (m_hist[c][k]) if (m_hist[c][k] == m_held[c]) all_diff = 1'b0;
        m_pp[c] = all_diff && samp;
        m_rp[c] = all_diff && !samp;
        if (all_diff) begin
          m_held[c] = samp;
          m_hist[c].delete();
        end
      end
      m_any = |m_pp;
      m_d2 = m_d1;
      m_d1 = btn_raw;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("model.pressed", 32'(pressed), 32'(m_held));
      chk("model.press_pulse", 32'(press_pulse), 32'(m_pp));
      chk("model.release_pulse", 32'(release_pulse), 32'(m_rp));
      chk("model.any_press", 32'(any_press), 32'(m_any));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int cnt_pp;
  int bad_hold;

  initial begin
    // Reset with all buttons idle.
    btn_raw = 5'b11111;
    tick(3);
    reset = 1'b1;
    chk("reset.pressed", 32'(pressed), 32'h0);
    chk("reset.press_pulse", 32'(press_pulse), 32'h0);
    chk("reset.release_pulse", 32'(release_pulse), 32'h0);
    chk("reset.any_press", 32'(any_press), 32'h0);
    cnt_pp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (press_pulse != 0 || release_pulse != 0 || any_press) cnt_pp++;
    end
    chk("reset.quiet_20", 32'(cnt_pp), 32'h0);

    // Clean press and release on channel 0.
    btn_raw[0] = 1'b0;
    tick(5);
    chk("press0.before", 32'(pressed), 32'h0);
    tick();
    chk("press0.pressed", 32'(pressed), 32'h01);
    chk("press0.pulse", 32'(press_pulse), 32'h01);
    chk("press0.any", 32'(any_press), 32'h1);
    tick();
    chk("press0.pulse_end", 32'(press_pulse), 32'h00);
    chk("press0.any_end", 32'(any_press), 32'h0);
    btn_raw[0] = 1'b1;
    tick(5);
    chk("rel0.before", 32'(release_pulse), 32'h00);
    tick();
    chk("rel0.pulse", 32'(release_pulse), 32'h01);
    chk("rel0.pressed", 32'(pressed), 32'h00);
    tick(3);

    // Bounce on channel 2: 3 low, 1 high, 3 low, then high -> rejected.
    cnt_pp = 0;
    btn_raw[2] = 1'b0; tick(3); cnt_pp += int'(press_pulse[2]);
    btn_raw[2] = 1'b1; tick(1); cnt_pp += int'(press_pulse[2]);
    btn_raw[2] = 1'b0; tick(3); cnt_pp += int'(press_pulse[2]);
    btn_raw[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt_pp += int'(press_pulse[2]) + int'(pressed[2]);
    end
    chk("bounce.rejected", 32'(cnt_pp), 32'h0);
    // A 4-cycle low is accepted exactly once.
    cnt_pp = 0;
    btn_raw[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); cnt_pp += int'(press_pulse[2]); end
    btn_raw[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); cnt_pp += int'(press_pulse[2]); end
    chk("bounce.accept4", 32'(cnt_pp), 32'h1);
    chk("bounce.released", 32'(pressed), 32'h0);

    // Simultaneous presses.
    btn_raw = 5'b00110;
    tick(6);
    chk("simul.pulse", 32'(press_pulse), 32'h19);
    chk("simul.any", 32'(any_press), 32'h1);
    tick();
    chk("simul.pulse_end", 32'(press_pulse), 32'h00);
    chk("simul.any_end", 32'(any_press), 32'h0);
    btn_raw = 5'b11111;
    tick(8);

    // Reset while channel 1 is counting, button held through release.
    btn_raw[1] = 1'b0;
    tick(4);
    reset = 1'b0;
    #1;
    chk("rstmid.pressed", 32'(pressed), 32'h0);
    chk("rstmid.pulse", 32'(press_pulse), 32'h0);
    tick(3);
    chk("rstmid.quiet", 32'(press_pulse), 32'h0);
    reset = 1'b1;
    tick(5);
    chk("rstmid.before", 32'(press_pulse), 32'h00);
    tick();
    chk("rstmid.pulse1", 32'(press_pulse), 32'h02);
    btn_raw[1] = 1'b1;
    tick(8);

    // Long hold on channel 4.
    cnt_pp = 0;
    bad_hold = 0;
    btn_raw[4] = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      cnt_pp += int'(press_pulse[4]);
      if (i >= 6 && !pressed[4]) bad_hold++;
    end
    chk("hold.one_pulse", 32'(cnt_pp), 32'h1);
    chk("hold.level", 32'(bad_hold), 32'h0);
    btn_raw[4] = 1'b1;
    tick(10);
    chk("hold.released", 32'(pressed), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
